enc_frame_ctrl: RTL and testbench
=================================

ENC_FRAME_CTRL -- requirements
Module: enc_frame_ctrl

Interface
REQ-001 SHALL have parameter K, default 9, constraint length and width of each generator polynomial.
REQ-002 SHALL have parameter FRAME_PAIRS, default 160, 2-bit input pairs per frame.
REQ-003 SHALL have parameter TIMEOUT, default 16, cycles allowed in WAIT_DONE.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports: i_start  in  1  frame request; i_code_rate  in  1  `CODE_RATE_2/`CODE_RATE_3 select; i_gen_poly  in  3*K  three polynomials, poly0 in LSBs.
REQ-006 SHALL have ports: i_tx_valid  in  1; i_tx_data  in  2  bit pair; o_tx_ready  out  1.
REQ-007 SHALL have encoder-side ports: o_enc_rst_n  out  1  active-low encoder clear; o_en_ce  out  1; o_code_rate  out  1; o_gen_poly  out  3*K; o_tx_data  out  2; i_encoder_done  in  1.
REQ-008 SHALL have status ports: o_busy  out  1; o_frame_done  out  1  one-cycle pulse; o_err  out  1  one-cycle pulse.

Function
REQ-009 SHALL implement states IDLE, CLEAR, PRIME, RUN, WAIT_DONE, FINISH; all outputs registered.
REQ-010 IDLE: i_start=1 -> latch i_code_rate and i_gen_poly into o_code_rate/o_gen_poly, go CLEAR; i_start ignored in every other state.
REQ-011 CLEAR: o_enc_rst_n=0 for exactly one cycle, o_en_ce=0, then PRIME.
REQ-012 PRIME: o_enc_rst_n=1, o_en_ce=1 for exactly one cycle with o_tx_data=0 (encoder slice delay), then RUN.
REQ-013 RUN: o_tx_ready=1; transfer when i_tx_valid & o_tx_ready; on transfer o_en_ce=1 and o_tx_data=i_tx_data in the same registered cycle; no transfer -> o_en_ce=0, o_tx_data holds.
REQ-014 Pair counter (width clog2(FRAME_PAIRS+1)) cleared in CLEAR, +1 per transfer; transfer making it FRAME_PAIRS -> WAIT_DONE, o_tx_ready=0 from next cycle.
REQ-015 WAIT_DONE: o_en_ce=1, o_tx_data=0, o_tx_ready=0; i_encoder_done=1 -> FINISH.
REQ-016 FINISH: o_frame_done=1 one cycle, o_en_ce=0, then IDLE; o_enc_rst_n stays 1 so encoder output remains readable until next CLEAR.
REQ-017 o_busy=1 in every state except IDLE.
REQ-018 i_encoder_done=1 in any state other than WAIT_DONE SHALL be ignored.
REQ-019 o_gen_poly/o_code_rate SHALL be stable from CLEAR through FINISH regardless of input changes.
REQ-020 i_tx_valid while not in RUN SHALL be ignored; no data consumed.

Reset
REQ-021 rst=1 SHALL asynchronously force IDLE, counters 0, o_enc_rst_n=0, o_en_ce=0, o_tx_ready=0, o_busy=0, o_frame_done=0, o_err=0, o_tx_data=0, o_code_rate=0, o_gen_poly=0.
REQ-022 o_enc_rst_n SHALL return to 1 on the first clock edge after rst deasserts, in IDLE.
REQ-023 Reset mid-frame SHALL abort with no o_frame_done or o_err pulse.

Configuration
REQ-024 Macro ENC_CTRL_TIMEOUT_EN defined: watchdog counts WAIT_DONE cycles; reaching TIMEOUT without i_encoder_done -> o_err=1 one cycle, o_enc_rst_n=0 one cycle, go IDLE, no o_frame_done.
REQ-025 Macro ENC_CTRL_TIMEOUT_EN undefined: no watchdog logic, WAIT_DONE waits indefinitely, o_err tied 0.

Verification
REQ-026 rst, then i_start with rate 2, 160 back-to-back valid pairs, done after 2 WAIT_DONE cycles -> one CLEAR cycle, one PRIME cycle, 160 o_en_ce cycles in RUN, o_frame_done pulse, o_busy low next cycle.
REQ-027 Rate 3 frame with i_tx_valid toggling every other cycle -> o_en_ce only on transfer cycles in RUN, exactly 160 pairs forwarded in order, o_tx_data matches input sequence.
REQ-028 i_start and changed i_gen_poly mid-RUN -> ignored; o_gen_poly unchanged; frame completes normally.
REQ-029 rst asserted after 50 transfers -> immediate IDLE, o_en_ce=0, o_enc_rst_n=0; no o_frame_done; next i_start runs full frame from count 0.
REQ-030 With ENC_CTRL_TIMEOUT_EN, i_encoder_done held 0 -> o_err pulse exactly 16 cycles after WAIT_DONE entry, encoder cleared, IDLE; without macro -> remains in WAIT_DONE, o_busy=1.
REQ-031 i_encoder_done pulsed during RUN -> ignored; frame still requires 160 transfers.

Source files
------------

// File: rtl/enc_frame_ctrl.sv
// -----------------------------------------------------------------------------
// enc_frame_ctrl
//
// Frame sequencer for a convolutional encoder. One frame goes through these
// steps:
//   1. Latch the code rate and the generator polynomials.
//   2. Clear the encoder for one cycle.
//   3. Prime the encoder for one cycle, feeding it zeros to cover its slice
//      delay.
//   4. Forward FRAME_PAIRS 2-bit input pairs to the encoder.
//   5. Clock the encoder with zero data until it reports done.
//   6. Pulse o_frame_done.
// Every output comes straight from a flop.
//
// Parameters
//   K           constraint length, also the width of each generator polynomial
//   FRAME_PAIRS number of 2-bit input pairs in one frame
//   TIMEOUT     number of cycles allowed in WAIT_DONE (watchdog build only)
//
// Build option
//   ENC_CTRL_TIMEOUT_EN  When defined, a watchdog runs in WAIT_DONE. If it
//                        expires, o_err pulses, the encoder is cleared and the
//                        FSM returns to IDLE. When undefined, there is no
//                        watchdog and o_err is tied to 0.
//
// Ports
//   clk, rst        clock and asynchronous active-high reset
//   i_start         frame request (sampled only in IDLE)
//   i_code_rate     code-rate select (`CODE_RATE_2 / `CODE_RATE_3)
//   i_gen_poly      three K-bit polynomials, poly0 in the LSBs
//   i_tx_valid      source has a pair available
//   i_tx_data       the 2-bit pair
//   o_tx_ready      controller accepts a pair (RUN only)
//   o_enc_rst_n     active-low encoder clear
//   o_en_ce         encoder clock enable
//   o_code_rate     latched code rate
//   o_gen_poly      latched polynomials
//   o_tx_data       pair presented to the encoder
//   i_encoder_done  encoder has flushed its output (honoured in WAIT_DONE only)
//   o_busy          high in every state except IDLE
//   o_frame_done    one-cycle pulse when a frame completes
//   o_err           one-cycle pulse when the watchdog expires
// -----------------------------------------------------------------------------
`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module enc_frame_ctrl #(
    parameter int K           = 9,
    parameter int FRAME_PAIRS = 160,
    parameter int TIMEOUT     = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic           i_code_rate,
    input  logic [3*K-1:0] i_gen_poly,
    input  logic           i_tx_valid,
    input  logic [1:0]     i_tx_data,
    output logic           o_tx_ready,
    output logic           o_enc_rst_n,
    output logic           o_en_ce,
    output logic           o_code_rate,
    output logic [3*K-1:0] o_gen_poly,
    output logic [1:0]     o_tx_data,
    input  logic           i_encoder_done,
    output logic           o_busy,
    output logic           o_frame_done,
    output logic           o_err
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PRIME,
        RUN,
        WAIT_DONE,
        FINISH
    } state_t;

    localparam int             CW      = $clog2(FRAME_PAIRS + 1);
    localparam logic [CW-1:0]  LAST_IX = CW'(FRAME_PAIRS - 1);

    if (K < 1 || FRAME_PAIRS < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("enc_frame_ctrl: K, FRAME_PAIRS and TIMEOUT must all be >= 1");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             enc_rst_n_d;
    logic             en_ce_d;
    logic             tx_ready_d;
    logic             busy_d;
    logic             frame_done_d;
    logic             code_rate_d;
    logic [3*K-1:0]   gen_poly_d;
    logic [1:0]       tx_data_d;

`ifdef ENC_CTRL_TIMEOUT_EN
    localparam int            WW      = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    // Next state and next output values. Each output flop is loaded with the
    // value that belongs to the cycle after the edge. This is why the last
    // transfer of a frame is still seen with o_en_ce=1 in the first WAIT_DONE
    // cycle.
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        //       path can leave a value unassigned and infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        enc_rst_n_d  = 1'b1;
        en_ce_d      = 1'b0;
        tx_ready_d   = 1'b0;
        frame_done_d = 1'b0;
        code_rate_d  = o_code_rate;
        gen_poly_d   = o_gen_poly;
        tx_data_d    = o_tx_data;
`ifdef ENC_CTRL_TIMEOUT_EN
        wd_d         = '0;
        err_d        = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d     = CLEAR;
                    enc_rst_n_d = 1'b0;
                    code_rate_d = i_code_rate;
                    gen_poly_d  = i_gen_poly;
                end
            end
            CLEAR: begin
                state_d   = PRIME;
                cnt_d     = '0;
                en_ce_d   = 1'b1;
                tx_data_d = 2'b00;
            end
            PRIME: begin
                state_d    = RUN;
                tx_ready_d = 1'b1;
            end
            RUN: begin
                tx_ready_d = 1'b1;
                if (i_tx_valid && o_tx_ready) begin
                    en_ce_d   = 1'b1;
                    tx_data_d = i_tx_data;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_IX) begin
                        state_d    = WAIT_DONE;
                        tx_ready_d = 1'b0;
                    end
                end
            end
            WAIT_DONE: begin
                if (i_encoder_done) begin
                    state_d      = FINISH;
                    frame_done_d = 1'b1;
                end else begin
                    // Keep clocking zeros through the encoder until it
                    // reports done.
                    en_ce_d   = 1'b1;
                    tx_data_d = 2'b00;
`ifdef ENC_CTRL_TIMEOUT_EN
                    if (wd_q == WD_LAST) begin
                        state_d     = IDLE;
                        err_d       = 1'b1;
                        enc_rst_n_d = 1'b0;
                        en_ce_d     = 1'b0;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
`endif
                end
            end
            FINISH: begin
                // o_enc_rst_n stays high so the encoder result can still be
                // read.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state and output flops use non-blocking assignments, so every
    //       flop samples values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            o_enc_rst_n  <= 1'b0;
            o_en_ce      <= 1'b0;
            o_tx_ready   <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_tx_data    <= 2'b00;
            o_code_rate  <= 1'b0;
            o_gen_poly   <= '0;
`ifdef ENC_CTRL_TIMEOUT_EN
            wd_q         <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            o_enc_rst_n  <= enc_rst_n_d;
            o_en_ce      <= en_ce_d;
            o_tx_ready   <= tx_ready_d;
            o_busy       <= busy_d;
            o_frame_done <= frame_done_d;
            o_tx_data    <= tx_data_d;
            o_code_rate  <= code_rate_d;
            o_gen_poly   <= gen_poly_d;
`ifdef ENC_CTRL_TIMEOUT_EN
            wd_q         <= wd_d;
            err_q        <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_enc_frame_ctrl.sv
`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module tb_enc_frame_ctrl;

    localparam int K  = 9;
    localparam int NP = 160;
    localparam int PW = 3 * K;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_code_rate = 1'b0;
    logic [PW-1:0] i_gen_poly = '0;
    logic          i_tx_valid = 1'b0;
    logic [1:0]    i_tx_data = 2'b00;
    logic          o_tx_ready;
    logic          o_enc_rst_n;
    logic          o_en_ce;
    logic          o_code_rate;
    logic [PW-1:0] o_gen_poly;
    logic [1:0]    o_tx_data;
    logic          i_encoder_done = 1'b0;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_err;

    int checks = 0;
    int errors = 0;

    // Expected values kept by the bench
    logic [PW-1:0] exp_poly;
    logic          exp_rate;
    logic [1:0]    exp_data;
    int            total_sent;

    enc_frame_ctrl #(.K(K), .FRAME_PAIRS(NP), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .i_start(i_start), .i_code_rate(i_code_rate), .i_gen_poly(i_gen_poly),
        .i_tx_valid(i_tx_valid), .i_tx_data(i_tx_data), .o_tx_ready(o_tx_ready),
        .o_enc_rst_n(o_enc_rst_n), .o_en_ce(o_en_ce), .o_code_rate(o_code_rate),
        .o_gen_poly(o_gen_poly), .o_tx_data(o_tx_data),
        .i_encoder_done(i_encoder_done),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked at
    // that same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] pat(input int i);
        pat = 2'((i * 3 + i / 5) % 4);
    endfunction

    // Go from IDLE to the first RUN cycle, checking CLEAR and PRIME on the way.
    task automatic start_frame(input logic rate, input logic [PW-1:0] poly);
        exp_poly    = poly;
        exp_rate    = rate;
        total_sent  = 0;
        i_start     = 1'b1;
        i_code_rate = rate;
        i_gen_poly  = poly;
        step();
        check("clear_enc_rst_n", o_enc_rst_n, 0);
        check("clear_en_ce",     o_en_ce, 0);
        check("clear_busy",      o_busy, 1);
        check("clear_poly",      o_gen_poly, exp_poly);
        check("clear_rate",      o_code_rate, exp_rate);
        // These changes must all be ignored: new inputs, a valid pair before RUN.
        i_start     = 1'b0;
        i_gen_poly  = ~poly;
        i_code_rate = ~rate;
        i_tx_valid  = 1'b1;
        i_tx_data   = 2'b11;
        step();
        check("prime_enc_rst_n", o_enc_rst_n, 1);
        check("prime_en_ce",     o_en_ce, 1);
        check("prime_tx_data",   o_tx_data, 0);
        check("prime_tx_ready",  o_tx_ready, 0);
        step();
        check("run_tx_ready",    o_tx_ready, 1);
        check("run_en_ce_idle",  o_en_ce, 0);
        check("run_poly_stable", o_gen_poly, exp_poly);
        check("run_rate_stable", o_code_rate, exp_rate);
        i_tx_valid = 1'b0;
        exp_data   = 2'b00;
    endtask

    // Send n pairs. With toggle set, i_tx_valid is high only every other
    // cycle. With pokes set, a mid-RUN i_start with a new polynomial is driven,
    // and i_encoder_done is pulsed.
    task automatic feed(input int n, input bit toggle, input bit pokes);
        int sent = 0;
        int cyc  = 0;
        logic v;
        while (sent < n && cyc < 1000) begin
            v          = toggle ? (cyc % 2 == 0) : 1'b1;
            i_tx_valid = v;
            i_tx_data  = pat(total_sent);
            if (pokes) begin
                i_start        = (cyc == 3);
                i_gen_poly     = (cyc >= 3) ? ~exp_poly : exp_poly;
                i_encoder_done = (cyc % 7 == 5);
            end
            step();
            check("run_en_ce", o_en_ce, v);
            if (v) begin
                exp_data = pat(total_sent);
                sent++;
                total_sent++;
            end
            check("run_tx_data", o_tx_data, exp_data);
            check("run_tx_ready_cnt", o_tx_ready, (total_sent != NP));
            cyc++;
        end
        if (sent < n) check("feed_budget", sent, n);
        i_tx_valid     = 1'b0;
        i_start        = 1'b0;
        i_encoder_done = 1'b0;
        i_gen_poly     = exp_poly;
        check("feed_poly_stable", o_gen_poly, exp_poly);
        check("feed_busy", o_busy, 1);
    endtask

    // Called in the first WAIT_DONE cycle. i_encoder_done goes high in the
    // second WAIT_DONE cycle.
    task automatic finish_frame();
        check("wd1_en_ce", o_en_ce, 1);
        step();
        check("wd2_en_ce",    o_en_ce, 1);
        check("wd2_tx_data",  o_tx_data, 0);
        check("wd2_tx_ready", o_tx_ready, 0);
        check("wd2_busy",     o_busy, 1);
        i_encoder_done = 1'b1;
        step();
        i_encoder_done = 1'b0;
        check("fin_frame_done", o_frame_done, 1);
        check("fin_en_ce",      o_en_ce, 0);
        check("fin_busy",       o_busy, 1);
        check("fin_enc_rst_n",  o_enc_rst_n, 1);
        check("fin_err",        o_err, 0);
        step();
        check("idle_frame_done", o_frame_done, 0);
        check("idle_busy",       o_busy, 0);
        check("idle_enc_rst_n",  o_enc_rst_n, 1);
        check("idle_poly_kept",  o_gen_poly, exp_poly);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_enc_rst_n",  o_enc_rst_n, 0);
        check("rst_en_ce",      o_en_ce, 0);
        check("rst_tx_ready",   o_tx_ready, 0);
        check("rst_busy",       o_busy, 0);
        check("rst_frame_done", o_frame_done, 0);
        check("rst_err",        o_err, 0);
        check("rst_tx_data",    o_tx_data, 0);
        check("rst_poly",       o_gen_poly, 0);
        check("rst_rate",       o_code_rate, 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_enc_rst_n", o_enc_rst_n, 1);
        check("post_rst_busy",      o_busy, 0);

        // Frame 1: rate 2, back-to-back pairs
        start_frame(`CODE_RATE_2, 27'h52A_B3C1);
        feed(NP, 1'b0, 1'b0);
        finish_frame();

        // Frame 2: rate 3, valid toggling, mid-RUN start/poly change and
        // stray done pulses
        start_frame(`CODE_RATE_3, 27'h1F0_0E5D);
        feed(NP, 1'b1, 1'b1);
        finish_frame();

        // Reset after 50 transfers, then a full frame from count 0
        start_frame(`CODE_RATE_2, 27'h3C3_5A5A);
        feed(50, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("abort_en_ce",     o_en_ce, 0);
        check("abort_enc_rst_n", o_enc_rst_n, 0);
        check("abort_busy",      o_busy, 0);
        check("abort_tx_ready",  o_tx_ready, 0);
        check("abort_poly",      o_gen_poly, 0);
        step();
        check("abort_frame_done", o_frame_done, 0);
        check("abort_err",        o_err, 0);
        rst = 1'b0;
        step();
        check("abort_idle_enc_rst_n", o_enc_rst_n, 1);
        check("abort_idle_frame_done", o_frame_done, 0);
        start_frame(`CODE_RATE_3, 27'h0A5_F00F);
        feed(NP, 1'b0, 1'b0);
        finish_frame();

        // i_encoder_done held low in WAIT_DONE
        start_frame(`CODE_RATE_2, 27'h123_4567);
        feed(NP, 1'b0, 1'b0);
`ifdef ENC_CTRL_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k < 16) begin
                check("wdog_err_low", o_err, 0);
                check("wdog_busy",    o_busy, 1);
            end else begin
                check("wdog_err_pulse",  o_err, 1);
                check("wdog_enc_rst_n",  o_enc_rst_n, 0);
                check("wdog_idle",       o_busy, 0);
                check("wdog_frame_done", o_frame_done, 0);
            end
        end
        step();
        check("wdog_err_one_cycle", o_err, 0);
        check("wdog_enc_rst_n_up",  o_enc_rst_n, 1);
`else
        for (int k = 1; k <= 20; k++) begin
            step();
            check("hang_busy",  o_busy, 1);
            check("hang_err",   o_err, 0);
            check("hang_en_ce", o_en_ce, 1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("hang_recover_idle", o_busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
